// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the multi-cycle hazard unit.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

    localparam int REGW_DEF = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // M stage wins over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_MEM;
        end else if (hit_w) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy timer for the multi-cycle multiply/divide unit.
// A start pulse is accepted only while idle; later starts are ignored until it drains.
module md_busy_counter #(
    parameter int LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [7:0] LAT8 = LATENCY[7:0];

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else if (start) begin
            cnt_d = LAT8;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != 8'd0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/mult-div stalls, flushes.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REGW       = REGW_DEF,
    parameter int MD_LATENCY = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branchD,
    input  logic            memtoregE,
    input  logic            regwriteE,
    input  logic            memtoregM,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    input  logic            branchCorrectE,
    input  logic            mdstartE,
    input  logic            mdopD,
    output logic            stallF,
    output logic            stallD,
    output logic            flushE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mdbusy,
    output logic [31:0]     stallcnt,
    output logic [31:0]     flushcnt
);

    logic md_busy;
    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall_any;
    logic flush_any;

    md_busy_counter #(
        .LATENCY(MD_LATENCY)
    ) u_md_busy (
        .clk  (clk),
        .reset(reset),
        .start(mdstartE),
        .busy (md_busy)
    );

    always_comb begin
        forwardAE = fwd_sel((rsE != '0) && (rsE == writeregM) && regwriteM,
                            (rsE != '0) && (rsE == writeregW) && regwriteW);
        forwardBE = fwd_sel((rtE != '0) && (rtE == writeregM) && regwriteM,
                            (rtE != '0) && (rtE == writeregW) && regwriteW);
        forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;
    end

    always_comb begin
        lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));

        branchstall = branchD &&
            ((regwriteE && (writeregE != '0) &&
              ((writeregE == rsD) || (writeregE == rtD))) ||
             (memtoregM && (writeregM != '0) &&
              ((writeregM == rsD) || (writeregM == rtD))));

        // Gated by reset so a start pending on the input cannot hold decode during reset.
        mdstall = mdopD && (mdstartE || md_busy) && !reset;

        stall_any = lwstall || branchstall || mdstall;
        flush_any = stall_any || branchCorrectE;
    end

    assign stallF = stall_any;
    assign stallD = stall_any;
    assign flushE = flush_any;
    assign mdbusy = md_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallcnt_q;
    logic [31:0] stallcnt_d;
    logic [31:0] flushcnt_q;
    logic [31:0] flushcnt_d;

    always_comb begin
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        if (stall_any) begin
            stallcnt_d = sat_inc32(stallcnt_q);
        end
        if (flush_any) begin
            flushcnt_d = sat_inc32(flushcnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcnt_q <= 32'd0;
            flushcnt_q <= 32'd0;
        end else begin
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign stallcnt = stallcnt_q;
    assign flushcnt = flushcnt_q;
`else
    assign stallcnt = 32'd0;
    assign flushcnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed scoreboard bench for hazard_unit_mc (MD_LATENCY=4).
// Expected values are queued as each step is driven and drained at the sample point.
module tb_hazard_unit_mc;

    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW;
    logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic            branchCorrectE, mdstartE, mdopD;
    logic            stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;
    logic [1:0]      forwardAE, forwardBE;
    logic [31:0]     stallcnt, flushcnt;

    int total = 0;
    int bad   = 0;

    int          id_q[$];
    logic [31:0] exp_q[$];

    localparam int O_STF = 0, O_STD = 1, O_FLE = 2, O_FAD = 3, O_FBD = 4;
    localparam int O_FAE = 5, O_FBE = 6, O_MDB = 7, O_SCN = 8, O_FCN = 9;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REGW      (REGW),
        .MD_LATENCY(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branchD       (branchD),
        .memtoregE     (memtoregE),
        .regwriteE     (regwriteE),
        .memtoregM     (memtoregM),
        .regwriteM     (regwriteM),
        .regwriteW     (regwriteW),
        .rsD           (rsD),
        .rtD           (rtD),
        .rsE           (rsE),
        .rtE           (rtE),
        .writeregE     (writeregE),
        .writeregM     (writeregM),
        .writeregW     (writeregW),
        .branchCorrectE(branchCorrectE),
        .mdstartE      (mdstartE),
        .mdopD         (mdopD),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushE        (flushE),
        .forwardAD     (forwardAD),
        .forwardBD     (forwardBD),
        .forwardAE     (forwardAE),
        .forwardBE     (forwardBE),
        .mdbusy        (mdbusy),
        .stallcnt      (stallcnt),
        .flushcnt      (flushcnt)
    );

    function automatic logic [31:0] obs(input int id);
        case (id)
            O_STF:   return {31'd0, stallF};
            O_STD:   return {31'd0, stallD};
            O_FLE:   return {31'd0, flushE};
            O_FAD:   return {31'd0, forwardAD};
            O_FBD:   return {31'd0, forwardBD};
            O_FAE:   return {30'd0, forwardAE};
            O_FBE:   return {30'd0, forwardBE};
            O_MDB:   return {31'd0, mdbusy};
            O_SCN:   return stallcnt;
            default: return flushcnt;
        endcase
    endfunction

    function automatic string oname(input int id);
        case (id)
            O_STF:   return "stallF";
            O_STD:   return "stallD";
            O_FLE:   return "flushE";
            O_FAD:   return "forwardAD";
            O_FBD:   return "forwardBD";
            O_FAE:   return "forwardAE";
            O_FBE:   return "forwardBE";
            O_MDB:   return "mdbusy";
            O_SCN:   return "stallcnt";
            default: return "flushcnt";
        endcase
    endfunction

    task automatic expv(input int id, input logic [31:0] v);
        id_q.push_back(id);
        exp_q.push_back(v);
    endtask

    task automatic exp_stall(input logic s, input logic f);
        expv(O_STF, {31'd0, s});
        expv(O_STD, {31'd0, s});
        expv(O_FLE, {31'd0, f});
    endtask

    task automatic check_now(input string tag);
        int          id;
        logic [31:0] e;
        logic [31:0] got;
        while (id_q.size() > 0) begin
            id  = id_q.pop_front();
            e   = exp_q.pop_front();
            got = obs(id);
            total++;
            assert (got === e) else begin
                bad++;
                $error("FAIL %s.%s observed=%0h expected=%0h", tag, oname(id), got, e);
            end
        end
    endtask

    task automatic clear_inputs();
        branchD = 0; memtoregE = 0; regwriteE = 0; memtoregM = 0;
        regwriteM = 0; regwriteW = 0; branchCorrectE = 0; mdstartE = 0; mdopD = 0;
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_scnt, exp_fcnt;

        reset = 1'b1;
        clear_inputs();
        #2;
        expv(O_MDB, 0); expv(O_SCN, 0); expv(O_FCN, 0); exp_stall(0, 0);
        check_now("reset");
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // E-stage forwarding priority
        rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
        expv(O_FAE, 2'b10); expv(O_FBE, 2'b00);
        @(negedge clk); check_now("fwdE_mem");
        regwriteM = 0;
        expv(O_FAE, 2'b01);
        @(negedge clk); check_now("fwdE_wb");
        rsE = 0;
        expv(O_FAE, 2'b00);
        @(negedge clk); check_now("fwdE_r0");
        rtE = 5; regwriteM = 1;
        expv(O_FBE, 2'b10); expv(O_FAE, 2'b00);
        @(negedge clk); check_now("fwdBE_mem");

        // Load-use stall
        next_cycle(); clear_inputs();
        memtoregE = 1; rtE = 7; rsD = 7;
        exp_stall(1, 1);
        @(negedge clk); check_now("lw_rs");
        rtE = 0; rsD = 0;
        exp_stall(0, 0);
        @(negedge clk); check_now("lw_r0");
        rtE = 7; rtD = 7; rsD = 2;
        exp_stall(1, 1);
        @(negedge clk); check_now("lw_rt");

        // Branch-compare hazards
        next_cycle(); clear_inputs();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        exp_stall(1, 1);
        @(negedge clk); check_now("br_E");
        next_cycle();
        regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 3;
        exp_stall(1, 1); expv(O_FAD, 0);
        @(negedge clk); check_now("br_M_load");
        memtoregM = 0; regwriteM = 1;
        exp_stall(0, 0); expv(O_FAD, 1); expv(O_FBD, 0);
        @(negedge clk); check_now("br_fwdAD");
        rsD = 0; rtD = 3;
        expv(O_FAD, 0); expv(O_FBD, 1);
        @(negedge clk); check_now("br_fwdBD");
        rtD = 0; writeregM = 0;
        expv(O_FAD, 0); expv(O_FBD, 0); exp_stall(0, 0);
        @(negedge clk); check_now("br_r0");

        next_cycle(); clear_inputs();
        branchCorrectE = 1;
        exp_stall(0, 1);
        @(negedge clk); check_now("squash");

        // Mult/div busy window: start in cycle 0, busy cycles 1..4
        next_cycle(); clear_inputs();
        mdstartE = 1; mdopD = 1;
        expv(O_MDB, 0); exp_stall(1, 1);
        @(negedge clk); check_now("md_c0");
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            mdstartE = (c == 2);
            expv(O_MDB, 1); exp_stall(1, 1);
            @(negedge clk); check_now($sformatf("md_c%0d", c));
        end
        next_cycle();
        mdstartE = 0;
        expv(O_MDB, 0); exp_stall(0, 0);
        @(negedge clk); check_now("md_c5");

        // Start coincident with a squash, then reset mid-busy
        next_cycle(); clear_inputs();
        mdstartE = 1; branchCorrectE = 1;
        expv(O_MDB, 0); exp_stall(0, 1);
        @(negedge clk); check_now("mdflush_c0");
        next_cycle();
        mdstartE = 0; branchCorrectE = 0;
        expv(O_MDB, 1);
        @(negedge clk); check_now("mdflush_c1");
        next_cycle();
        mdopD = 1;
        expv(O_MDB, 1); exp_stall(1, 1);
        @(negedge clk); check_now("mdrst_c2");
        #1;
        reset = 1'b1; mdstartE = 1;
        #1;
        expv(O_MDB, 0); exp_stall(0, 0); expv(O_SCN, 0); expv(O_FCN, 0);
        check_now("mdrst_async");
        next_cycle();
        reset = 1'b0; clear_inputs();

        // Performance counters: 10 load-use edges then one squash edge
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            memtoregE = 1; rtE = 7; rsD = 7;
        end
        next_cycle();
        clear_inputs(); branchCorrectE = 1;
        next_cycle();
        clear_inputs();
`ifdef HAZARD_PERF_EN
        exp_scnt = 32'd10; exp_fcnt = 32'd11;
`else
        exp_scnt = 32'd0;  exp_fcnt = 32'd0;
`endif
        expv(O_SCN, exp_scnt); expv(O_FCN, exp_fcnt);
        @(negedge clk); check_now("perf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
